mux_nx1_scan: RTL
=================

MUX_NX1_SCAN -- requirements
Module: mux_nx1_scan

Interface
REQ-001 Parameter: SEL_W, default 4, select width; channel count N = 2**SEL_W.
REQ-002 Parameter: W, default 1, data width per channel.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: di  input  N*W  channel data; channel k occupies di[k*W +: W].
REQ-006 Port: si  input  SEL_W  manual channel select.
REQ-007 Port: mode  input  1  0 = manual, 1 = auto-scan.
REQ-008 Port: start  input  1  scan request, sampled in IDLE only.
REQ-009 Port: y  output  W  registered selected data.
REQ-010 Port: ch  output  SEL_W  channel index of the current y.
REQ-011 Port: y_valid  output  1  y/ch hold a valid sample.
REQ-012 Port: y_rdy  input  1  consumer accepts y; used only in SCAN.
REQ-013 Port: busy  output  1  high in SCAN and DONE.
REQ-014 Port: done  output  1  one-cycle pulse at scan completion.

Function
REQ-015 FSM states: IDLE, SCAN, DONE; encoding free.
REQ-016 IDLE, mode=0: each cycle y <= di[si], ch <= si, y_valid <= 1; latency exactly 1 cycle; y_rdy ignored.
REQ-017 IDLE, mode=1, start=0: y and ch hold; y_valid <= 0.
REQ-018 IDLE, mode=1, start=1: next cycle state = SCAN, y <= di[0], ch <= 0, y_valid <= 1.
REQ-019 start with mode=0 in IDLE is ignored.
REQ-020 Handshake: a transfer occurs on a cycle with y_valid=1 and y_rdy=1.
REQ-021 SCAN, no transfer: y, ch, y_valid hold (y is not re-sampled from di).
REQ-022 SCAN, transfer with ch < N-1: y <= di[ch+1], ch <= ch+1, y_valid stays 1; back-to-back transfers give one channel per cycle.
REQ-023 SCAN, transfer with ch = N-1: state = DONE, y_valid <= 0; ch does not wrap to 0 (holds N-1).
REQ-024 DONE: done = 1 for exactly that cycle, busy = 1; next state IDLE unconditionally.
REQ-025 start and mode are ignored in SCAN and DONE; a full scan always transfers N samples in order 0..N-1.
REQ-026 busy = 1 iff state is SCAN or DONE; done = 1 iff state is DONE.
REQ-027 Minimum scan duration with y_rdy held high: N cycles of SCAN + 1 cycle DONE.

Reset
REQ-028 rst=1 at a rising edge forces: state IDLE, y = 0, ch = 0, y_valid = 0, busy = 0, done = 0.
REQ-029 Reset takes priority over all other inputs, including mid-scan and in DONE; no done pulse is produced for an interrupted scan.
REQ-030 First cycle after rst deasserts behaves as IDLE per REQ-016..REQ-018.

Configuration
REQ-031 Macro MUX_SCAN_ABORT_EN adds input port abort (1 bit).
REQ-032 With MUX_SCAN_ABORT_EN: abort=1 in SCAN -> next state IDLE, y_valid <= 0, no done pulse, y/ch hold; abort takes priority over a simultaneous transfer; abort ignored in IDLE and DONE.
REQ-033 Without MUX_SCAN_ABORT_EN: no abort port; a scan ends only via REQ-023 or reset.

Verification (bench overrides W=8, SEL_W=4)
REQ-034 Manual sweep: mode=0, di[k]=8'h10+k, si=0..15 one per cycle -> each following cycle y=8'h10+si, ch=si, y_valid=1.
REQ-035 Full-rate scan: mode=1, start pulse, y_rdy=1 -> y=8'h10..8'h1F on 16 consecutive cycles, ch=0..15, then done=1 for one cycle, busy low after.
REQ-036 Backpressure: y_rdy low for 3 cycles while ch=5 and di changed mid-stall -> y holds 8'h15, ch=5; resumes with ch=6 after y_rdy high.
REQ-037 Ignored inputs: start pulsed and mode toggled at ch=8 -> scan continues unchanged to ch=15 and one done pulse.
REQ-038 Reset mid-scan: rst=1 at ch=10 -> next cycle y=0, ch=0, y_valid=0, busy=0, done never asserted.
REQ-039 With MUX_SCAN_ABORT_EN: abort=1 at ch=3 together with y_rdy=1 -> next cycle IDLE, y_valid=0, ch=3, no done.

Source files
------------

// File: rtl/mux_nx1_scan.sv
// Registered N:1 multiplexer with manual select and a handshaked auto-scan of all channels.
// Define MUX_SCAN_ABORT_EN to add an abort input that cancels a scan in progress.
module mux_nx1_scan #(
    parameter int SEL_W = 4,
    parameter int W     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [(2**SEL_W)*W-1:0]     di,
    input  logic [SEL_W-1:0]            si,
    input  logic                        mode,
    input  logic                        start,
    output logic [W-1:0]                y,
    output logic [SEL_W-1:0]            ch,
    output logic                        y_valid,
    input  logic                        y_rdy,
`ifdef MUX_SCAN_ABORT_EN
    input  logic                        abort,
`endif
    output logic                        busy,
    output logic                        done
);

    localparam int N = 2**SEL_W;
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       y_q, y_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               y_valid_q, y_valid_d;

    logic [W-1:0]       chan [N];
    logic [SEL_W-1:0]   ch_nxt;
    logic               xfer;
    logic               abort_req;

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chan[k] = di[k*W +: W];
    end

`ifdef MUX_SCAN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign ch_nxt = ch_q + SEL_W'(1);
    assign xfer   = y_valid_q && y_rdy;

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        ch_d      = ch_q;
        y_valid_d = y_valid_q;

        unique case (state_q)
            IDLE: begin
                if (!mode) begin
                    y_d       = chan[si];
                    ch_d      = si;
                    y_valid_d = 1'b1;
                end else if (start) begin
                    state_d   = SCAN;
                    y_d       = chan[0];
                    ch_d      = '0;
                    y_valid_d = 1'b1;
                end else begin
                    y_valid_d = 1'b0;
                end
            end

            SCAN: begin
                // Abort wins over a same-cycle transfer; y and ch keep the last sample.
                if (abort_req) begin
                    state_d   = IDLE;
                    y_valid_d = 1'b0;
                end else if (xfer) begin
                    if (ch_q == CH_LAST) begin
                        state_d   = DONE;
                        y_valid_d = 1'b0;
                    end else begin
                        y_d  = chan[ch_nxt];
                        ch_d = ch_nxt;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                y_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // together from the values computed before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            y_q       <= '0;
            ch_q      <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            ch_q      <= ch_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign ch      = ch_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q == SCAN) || (state_q == DONE);
    assign done    = (state_q == DONE);

endmodule
